// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit for RV32M (one quotient/product bit per clock).
// Fast path: divide-by-zero and signed overflow (MIN_NEG / -1) finish in a single cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic             neg_a_q, neg_b_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_q;    // product high half (mul) or partial remainder (div)
  logic [WIDTH-1:0] lo_q;     // product low half / multiplier (mul) or quotient / dividend (div)
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;

  logic accept, last;

  // Request decode: signedness, magnitudes and fast-path detection.
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             b_zero, ovf, fast;
  logic [WIDTH-1:0] fast_res;

  assign a_signed = (md_op == OP_MULH) || (md_op == OP_MULHSU) ||
                    (md_op == OP_DIV)  || (md_op == OP_REM);
  assign b_signed = (md_op == OP_MULH) || (md_op == OP_DIV) || (md_op == OP_REM);
  assign a_neg    = a_signed & A[WIDTH-1];
  assign b_neg    = b_signed & B[WIDTH-1];
  assign a_mag    = a_neg ? (~A + 1'b1) : A;
  assign b_mag    = b_neg ? (~B + 1'b1) : B;
  assign b_zero   = (B == '0);
  assign ovf      = ((md_op == OP_DIV) || (md_op == OP_REM)) && (A == MIN_NEG) && (B == '1);
  assign fast     = md_op[2] && (b_zero || ovf);
  // md_op[1] separates REM/REMU from DIV/DIVU.
  assign fast_res = b_zero ? (md_op[1] ? A : '1) : (md_op[1] ? '0 : A);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_d = fast ? DONE : BUSY;
      end
      BUSY: if (cnt_q == CNT_LAST) begin
        last    = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      accept  = 1'b0;
      last    = 1'b0;
    end
  end

  // One iteration step of each datapath plus sign correction of the final step.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   mul_acc_n, mul_lo_n, div_acc_n, div_lo_n, acc_n, lo_n;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc_n = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring division: a clear top bit of the difference means the trial subtract succeeded.
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_acc_n = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_lo_n  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

    acc_n = op_q[2] ? div_acc_n : mul_acc_n;
    lo_n  = op_q[2] ? div_lo_n  : mul_lo_n;

    prod     = {mul_acc_n, mul_lo_n};
    prod_fix = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
    quo_fix  = (neg_a_q ^ neg_b_q) ? (~div_lo_n + 1'b1) : div_lo_n;
    rem_fix  = neg_a_q ? (~div_acc_n + 1'b1) : div_acc_n;

    final_res = '0;
    unique case (op_q)
      OP_MUL:                       final_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      OP_REM, OP_REMU:              final_res = rem_fix;
      default:                      final_res = '0;
    endcase
  end

  // Datapath registers: latch operands on accept, iterate while BUSY, register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so no stale operand or result survives a reset.
    if (!rst_n) begin
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q    <= md_op;
      neg_a_q <= a_neg;
      neg_b_q <= b_neg;
      acc_q   <= '0;
      cnt_q   <= fast ? '0 : CNT_INIT;
      if (md_op[2]) begin
        opnd_q <= b_mag;
        lo_q   <= a_mag;
      end else begin
        opnd_q <= a_mag;
        lo_q   <= b_mag;
      end
      if (fast) result_q <= fast_res;
    end else if (state_q == BUSY) begin
      acc_q <= acc_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - 1'b1;
      if (last) result_q <= final_res;
    end
  end

endmodule
